row_decoder_seq: RTL
====================

// Module: row_decoder_seq
// PURPOSE
//  Clocked, parametrised successor to the combinational row decoder in the mixed-signal SRAM.
//  Samples a real-valued row address on a request and runs a timed access:
//  bitline precharge -> single wordline pulse -> recovery.
//  Drives real-valued wordlines and precharge enable into the analog array model.
//  Sits between the digital access controller and the SRAM cell array.
// PARAMETERS
//  ROWS        16   number of wordlines; need not be a power of two (>=2)
//  VDD         1.5  real high level driven on outputs (V)
//  VSS         0.0  real low level driven on outputs (V)
//  VTH         0.8  real threshold; input >= VTH reads as 1
//  PRE_CYCLES  2    precharge duration in clk cycles (>=1)
//  WL_CYCLES   4    wordline-high duration in clk cycles (>=1)
//  REC_CYCLES  1    recovery duration in clk cycles (>=1)
// PORTS
//  clk       in   1                logic clock; all state changes on posedge
//  rst_n     in   1                synchronous active-low reset
//  req       in   1                logic access request, sampled only in IDLE
//  row_sel   in   real[0:AW-1]     address bits, AW=$clog2(ROWS); index 0 = LSB
//  row_out   out  real[0:ROWS-1]   wordlines, VDD or VSS
//  pre_out   out  real             bitline precharge enable, VDD or VSS
//  busy      out  1                access in progress
//  done      out  1                one-cycle pulse on access completion
//  addr_err  out  1                one-cycle pulse: request rejected, address >= ROWS
// BEHAVIOUR
//  - Reset (rst_n=0 at posedge):
//    - state=IDLE; all counters cleared.
//    - row_out[*]=VSS, pre_out=VSS, busy=0, done=0, addr_err=0.
//    - Applies mid-access too: outputs return to VSS at that edge; the access is dropped with no done.
//  - Address conversion: bit k = (row_sel[k] >= VTH). The address maps directly: value N selects row_out[N], and 0 is a valid row.
//  - All outputs are registered; no combinational path from inputs to outputs.
//  - FSM (IDLE, PRECH, ACTIVE, RECOV):
//    - IDLE, req=1, addr<ROWS: latch addr, go to PRECH; busy=1 from next cycle.
//    - IDLE, req=1, addr>=ROWS: addr_err=1 for one cycle; remain IDLE; outputs unchanged.
//    - PRECH: pre_out=VDD for exactly PRE_CYCLES cycles, then ACTIVE.
//    - ACTIVE: pre_out=VSS; row_out[addr]=VDD and all others VSS, for exactly WL_CYCLES cycles; then RECOV.
//    - RECOV: all outputs VSS for REC_CYCLES cycles; then IDLE with done=1 for that first IDLE cycle.
//  - Mutual exclusion: pre_out and any row_out are never VDD in the same cycle. At most one row_out is VDD at any time.
//  - req and row_sel are ignored while busy=1. The latched addr is stable for the whole access.
//  - Back-to-back: req=1 in the done cycle is accepted; PRECH starts on the next cycle.
//  - Total latency: accept edge to done = PRE_CYCLES+WL_CYCLES+REC_CYCLES+1 cycles.
//  - Duration counter width: $clog2(max(PRE,WL,REC)+1).
//  - Elaboration error if any *_CYCLES < 1 or ROWS < 2.
// TESTING
//  1. Reset: rst_n=0 for 2 cycles -> all row_out=0.0, pre_out=0.0, busy=0, done=0, addr_err=0.
//  2. Defaults, row_sel=1.5,0,1.5,0 (addr 5), req 1 cycle ->
//     - pre_out=1.5 for 2 cycles;
//     - then row_out[5]=1.5 for 4 cycles, others 0.0;
//     - then 1 cycle all 0.0;
//     - then done=1 for 1 cycle; busy high for 7 cycles.
//  3. ROWS=12, addr 13 -> addr_err pulses 1 cycle; busy stays 0; all outputs stay 0.0.
//  4. Row_sel changed to addr 3 and req pulsed during ACTIVE of an addr 5 access -> row 5 completes; row 3 never asserted.
//  5. rst_n=0 in the 2nd ACTIVE cycle -> row_out[5]=0.0 at that edge; no done; next req starts a clean PRECH.
//  6. Threshold/back-to-back: row_sel[0]=0.79 then 0.80 -> rows 0 then 1; second req held high through the done cycle -> second PRECH immediately follows the done cycle.

Source files
------------

// File: rtl/row_decoder_seq_if.sv
// ---------------------------------------------------------------------------
// row_decoder_seq_if
//   Connection between the digital access controller (master) and the
//   clocked row decoder (slave) that drives the analog SRAM array model.
//
//   Parameters
//     ROWS      number of wordlines
//     AW        address width, $clog2(ROWS)
//
//   Signals
//     req       access request, sampled by the decoder only while idle
//     row_sel   real-valued address bits, index 0 = LSB
//     row_out   real-valued wordlines (VDD or VSS)
//     pre_out   real-valued bitline precharge enable (VDD or VSS)
//     busy      access in progress
//     done      one-cycle pulse on access completion
//     addr_err  one-cycle pulse when a request names a row >= ROWS
// ---------------------------------------------------------------------------
interface row_decoder_seq_if #(
    parameter int ROWS = 16,
    parameter int AW   = $clog2(ROWS)
);
    logic req;
    real  row_sel [0:AW-1];
    real  row_out [0:ROWS-1];
    real  pre_out;
    logic busy;
    logic done;
    logic addr_err;

    modport master (
        output req,
        output row_sel,
        input  row_out,
        input  pre_out,
        input  busy,
        input  done,
        input  addr_err
    );

    modport slave (
        input  req,
        input  row_sel,
        output row_out,
        output pre_out,
        output busy,
        output done,
        output addr_err
    );
endinterface

// File: rtl/row_decoder_seq.sv
// ---------------------------------------------------------------------------
// row_decoder_seq
//   Clocked row decoder for the mixed-signal SRAM. On an accepted request it
//   latches a thresholded real-valued row address and runs a timed access:
//   bitline precharge, then a single wordline pulse, then recovery. The
//   precharge enable and wordlines are driven as real levels into the
//   analog array model.
//
//   Ports
//     clk       clock, all state changes on posedge
//     rst_n     synchronous active-low reset
//     bus       row_decoder_seq_if.slave
//                 req, row_sel          in  : request and address bits
//                 row_out, pre_out      out : real wordlines / precharge
//                 busy, done, addr_err  out : status
//
//   Every output is a register (or a fixed level selected by a register),
//   so there is no combinational path from req/row_sel to any output.
// ---------------------------------------------------------------------------
module row_decoder_seq #(
    parameter int  ROWS       = 16,
    parameter real VDD        = 1.5,
    parameter real VSS        = 0.0,
    parameter real VTH        = 0.8,
    parameter int  PRE_CYCLES = 2,
    parameter int  WL_CYCLES  = 4,
    parameter int  REC_CYCLES = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    row_decoder_seq_if.slave  bus
);

    localparam int AW   = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int MAXC = (PRE_CYCLES > WL_CYCLES)
                          ? ((PRE_CYCLES > REC_CYCLES) ? PRE_CYCLES : REC_CYCLES)
                          : ((WL_CYCLES  > REC_CYCLES) ? WL_CYCLES  : REC_CYCLES);
    localparam int CW   = $clog2(MAXC + 1);

    if (ROWS < 2) begin : g_bad_rows
        $error("row_decoder_seq: ROWS must be at least 2");
    end
    if (PRE_CYCLES < 1) begin : g_bad_pre
        $error("row_decoder_seq: PRE_CYCLES must be at least 1");
    end
    if (WL_CYCLES < 1) begin : g_bad_wl
        $error("row_decoder_seq: WL_CYCLES must be at least 1");
    end
    if (REC_CYCLES < 1) begin : g_bad_rec
        $error("row_decoder_seq: REC_CYCLES must be at least 1");
    end

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        PRECH  = 2'd1,
        ACTIVE = 2'd2,
        RECOV  = 2'd3
    } state_t;

    state_t            state_q, state_nxt;
    logic [CW-1:0]     cnt_q, cnt_nxt;
    logic [AW-1:0]     addr_q, addr_nxt;
    logic [AW-1:0]     addr_in;
    logic              addr_ok;
    logic              pre_q, pre_nxt;
    logic              busy_q, busy_nxt;
    logic              done_q, done_nxt;
    logic              err_q, err_nxt;
    logic [ROWS-1:0]   wl_q, wl_nxt;

    // Analog input level to logic bit.
    function automatic logic to_bit(input real v);
        return (v >= VTH);
    endfunction

    // Counter value on the final cycle of a timed phase.
    function automatic logic [CW-1:0] last_count(input state_t s);
        case (s)
            PRECH:   last_count = CW'(PRE_CYCLES - 1);
            ACTIVE:  last_count = CW'(WL_CYCLES - 1);
            default: last_count = CW'(REC_CYCLES - 1);
        endcase
    endfunction

    // Address to one-hot wordline vector; rows beyond ROWS never match.
    function automatic logic [ROWS-1:0] row_onehot(input logic [AW-1:0] a);
        row_onehot = '0;
        for (int i = 0; i < ROWS; i++) begin
            if (a == AW'(i)) begin
                row_onehot[i] = 1'b1;
            end
        end
    endfunction

    always_comb begin
        addr_in = '0;
        for (int k = 0; k < AW; k++) begin
            addr_in[k] = to_bit(bus.row_sel[k]);
        end
    end

    // Zero-extended so the compare also works when ROWS == 2**AW.
    assign addr_ok = ({1'b0, addr_in} < (AW+1)'(ROWS));

    // Next-state and next-output logic. Outputs are computed from the next
    // state so that the registered outputs line up with the registered state.
    always_comb begin
        state_nxt = state_q;
        cnt_nxt   = cnt_q;
        addr_nxt  = addr_q;
        done_nxt  = 1'b0;
        err_nxt   = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.req) begin
                    if (addr_ok) begin
                        addr_nxt  = addr_in;
                        cnt_nxt   = '0;
                        state_nxt = PRECH;
                    end else begin
                        err_nxt = 1'b1;
                    end
                end
            end
            PRECH: begin
                if (cnt_q == last_count(PRECH)) begin
                    cnt_nxt   = '0;
                    state_nxt = ACTIVE;
                end else begin
                    cnt_nxt = cnt_q + CW'(1);
                end
            end
            ACTIVE: begin
                if (cnt_q == last_count(ACTIVE)) begin
                    cnt_nxt   = '0;
                    state_nxt = RECOV;
                end else begin
                    cnt_nxt = cnt_q + CW'(1);
                end
            end
            RECOV: begin
                if (cnt_q == last_count(RECOV)) begin
                    cnt_nxt   = '0;
                    state_nxt = IDLE;
                    done_nxt  = 1'b1;
                end else begin
                    cnt_nxt = cnt_q + CW'(1);
                end
            end
            default: begin
                cnt_nxt   = '0;
                state_nxt = IDLE;
            end
        endcase

        busy_nxt = (state_nxt != IDLE);
        pre_nxt  = (state_nxt == PRECH);
        wl_nxt   = '0;
        if (state_nxt == ACTIVE) begin
            wl_nxt = row_onehot(addr_nxt);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            pre_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            wl_q    <= '0;
        end else begin
            state_q <= state_nxt;
            cnt_q   <= cnt_nxt;
            pre_q   <= pre_nxt;
            busy_q  <= busy_nxt;
            done_q  <= done_nxt;
            err_q   <= err_nxt;
            wl_q    <= wl_nxt;
        end
    end

    // Latched address only matters while wl_q can be set, so it needs no reset.
    always_ff @(posedge clk) begin
        addr_q <= addr_nxt;
    end

    // Registered bits select fixed rail levels for the analog model.
    always_comb begin
        bus.pre_out = pre_q ? VDD : VSS;
        for (int i = 0; i < ROWS; i++) begin
            bus.row_out[i] = wl_q[i] ? VDD : VSS;
        end
    end

    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.addr_err = err_q;

endmodule
